// File: rtl/hough_sequencer.sv
// Raster-scans an edge bitmap and dispatches each edge pixel to a hough_transformer,
// waiting for the transformer to finish before moving to the next pixel.
module hough_sequencer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    output logic [18:0] edge_addr,
    input  logic        edge_data,
    output logic        ht_start,
    output logic [9:0]  ht_x,
    output logic [8:0]  ht_y,
    input  logic        ht_done,
    output logic        busy,
    output logic        frame_done,
    output logic [18:0] edge_count
);

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        FIRE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [18:0] addr;
    logic        step;

    // Address is tracked incrementally; raster order keeps it equal to y*WIDTH+x.
    assign edge_addr = addr;
    assign ht_x      = x;
    assign ht_y      = y;
    assign step      = ((state == CHECK) && !edge_data) || ((state == WAIT) && ht_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            edge_count <= '0;
            ht_start   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ht_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        x          <= '0;
                        y          <= '0;
                        addr       <= '0;
                        edge_count <= '0;
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end
                READ:  state <= CHECK;
                CHECK: begin
                    if (edge_data) begin
                        ht_start <= 1'b1;
                        state    <= FIRE;
                    end
                end
                FIRE: begin
                    edge_count <= edge_count + 19'd1;
                    state      <= WAIT;
                end
                WAIT: ;
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Pixel advance, shared by a blank pixel in CHECK and a finished one in WAIT.
            if (step) begin
                if ((x == X_LAST) && (y == Y_LAST)) begin
                    frame_done <= 1'b1;
                    state      <= DONE;
                end else begin
                    if (x == X_LAST) begin
                        x <= '0;
                        y <= y + 9'd1;
                    end else begin
                        x <= x + 10'd1;
                    end
                    addr  <= addr + 19'd1;
                    state <= READ;
                end
            end
        end
    end

endmodule

// File: tb/tb_hough_sequencer.sv
// Bench for hough_sequencer on an 8x4 image: a per-cycle timeline model built from the
// scan rules, a cycle-by-cycle compare process, and literal pins for each scenario.
module tb_hough_sequencer;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int MAXC = 2048;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic [18:0] edge_addr;
    logic        edge_data;
    logic        ht_start;
    logic [9:0]  ht_x;
    logic [8:0]  ht_y;
    logic        ht_done;
    logic        busy;
    logic        frame_done;
    logic [18:0] edge_count;

    hough_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .edge_addr  (edge_addr),
        .edge_data  (edge_data),
        .ht_start   (ht_start),
        .ht_x       (ht_x),
        .ht_y       (ht_y),
        .ht_done    (ht_done),
        .busy       (busy),
        .frame_done (frame_done),
        .edge_count (edge_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Edge bitmap memory with one-cycle read latency.
    bit bmp[NPIX];
    always @(posedge clk) edge_data <= bmp[edge_addr[4:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
        end
    endtask

    // Transformer stand-in: ht_done pulses in the lat-th cycle after the ht_start cycle;
    // with fire_high it is also high during the ht_start cycle itself.
    int lat = 1;
    bit fire_high = 1'b0;
    int since = -1;
    initial forever begin
        @(posedge clk);
        #2;
        if (ht_start) since = 0;
        else if (since >= 0) since++;
        ht_done = (since == 0 && fire_high) || (since == lat);
        if (since == lat) since = -1;
    end

    // Expected timeline indexed by cycle relative to the frame_start sampling edge.
    bit m_busy[MAXC];
    bit m_fd[MAXC];
    bit m_hs[MAXC];
    int m_addr[MAXC];
    int m_ec[MAXC];
    int mlen;

    function automatic void build_model();
        int t;
        for (int i = 0; i < MAXC; i++) begin
            m_busy[i] = 1'b0;
            m_fd[i]   = 1'b0;
            m_hs[i]   = 1'b0;
            m_addr[i] = -1;
            m_ec[i]   = 0;
        end
        t = 1;
        for (int p = 0; p < NPIX; p++) begin
            m_addr[t]     = p;
            m_addr[t + 1] = p;
            if (bmp[p]) begin
                m_hs[t + 2] = 1'b1;
                for (int j = t + 2; j <= t + 2 + lat; j++) m_addr[j] = p;
                t += 3 + lat;
            end else begin
                t += 2;
            end
        end
        mlen = t;
        m_fd[t] = 1'b1;
        for (int r = 1; r <= t; r++) m_busy[r] = 1'b1;
        for (int r = 1; r < MAXC; r++) m_ec[r] = m_ec[r - 1] + int'(m_hs[r - 1]);
    endfunction

    bit active = 1'b0;
    int e0 = 0;
    int fd_rel, fd_cnt, hs_cnt;
    int lx[$];
    int ly[$];
    int la[$];

    initial forever begin : compare
        int r;
        @(negedge clk);
        if (active) begin
            r = cyc - e0;
            if (r >= 1 && r <= mlen + 3) begin
                chk("busy", busy, m_busy[r]);
                chk("frame_done", frame_done, m_fd[r]);
                chk("ht_start", ht_start, m_hs[r]);
                chk("edge_count", edge_count, m_ec[r]);
                if (m_addr[r] >= 0) begin
                    chk("edge_addr", edge_addr, m_addr[r]);
                    chk("ht_x", ht_x, m_addr[r] % W);
                    chk("ht_y", ht_y, m_addr[r] / W);
                end
                if (frame_done) begin
                    fd_cnt++;
                    if (fd_rel < 0) fd_rel = r;
                end
                if (ht_start) begin
                    hs_cnt++;
                    lx.push_back(int'(ht_x));
                    ly.push_back(int'(ht_y));
                    la.push_back(int'(edge_addr));
                end
            end
        end
    end

    task automatic clear_bmp();
        for (int i = 0; i < NPIX; i++) bmp[i] = 1'b0;
    endtask

    task automatic run_frame(input int lt, input bit fh, input int pulse_rel);
        lat       = lt;
        fire_high = fh;
        build_model();
        fd_rel = -1;
        fd_cnt = 0;
        hs_cnt = 0;
        lx.delete();
        ly.delete();
        la.delete();
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        e0     = cyc;
        active = 1'b1;
        repeat (mlen + 4) begin
            @(posedge clk);
            #1;
            frame_start = (pulse_rel > 0) && (cyc - e0 == pulse_rel);
        end
        active      = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin : main
        int n;
        int fdc;
        int bsy;
        reset       = 1'b1;
        frame_start = 1'b0;
        clear_bmp();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_ht_start", ht_start, 0);
        chk("rst_edge_count", edge_count, 0);
        chk("rst_edge_addr", edge_addr, 0);
        chk("rst_ht_x", ht_x, 0);
        chk("rst_ht_y", ht_y, 0);
        reset = 1'b0;

        // All-zero bitmap: 32 pixels x 2 cycles, DONE at relative cycle 65.
        run_frame(1, 1'b0, 0);
        chk("zero_fd_cycle", fd_rel, 65);
        chk("zero_fd_count", fd_cnt, 1);
        chk("zero_starts", hs_cnt, 0);
        chk("zero_edge_count", edge_count, 0);

        // Single edge at (3,2); ht_done returns in the 22nd cycle after ht_start.
        bmp[2 * W + 3] = 1'b1;
        run_frame(22, 1'b0, 0);
        chk("one_fd_cycle", fd_rel, 88);
        chk("one_starts", hs_cnt, 1);
        chk("one_x", lx[0], 3);
        chk("one_y", ly[0], 2);
        chk("one_edge_count", edge_count, 1);

        // Edges at (7,0) and (0,1), done one cycle after each start.
        clear_bmp();
        bmp[7] = 1'b1;
        bmp[8] = 1'b1;
        run_frame(1, 1'b0, 0);
        chk("two_starts", hs_cnt, 2);
        chk("two_x0", lx[0], 7);
        chk("two_y0", ly[0], 0);
        chk("two_addr0", la[0], 7);
        chk("two_x1", lx[1], 0);
        chk("two_y1", ly[1], 1);
        chk("two_addr1", la[1], 8);
        chk("two_fd_cycle", fd_rel, 69);
        chk("two_edge_count", edge_count, 2);

        // ht_done high during FIRE, and frame_start pulsed mid-frame.
        clear_bmp();
        bmp[2] = 1'b1;
        run_frame(5, 1'b1, 30);
        chk("fh_fd_cycle", fd_rel, 71);
        chk("fh_fd_count", fd_cnt, 1);
        chk("fh_idle_busy", busy, 0);
        fire_high = 1'b0;

        // Reset while waiting on the transformer at (5,1).
        clear_bmp();
        bmp[1 * W + 5] = 1'b1;
        lat = 1000;
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        n = 0;
        while (!ht_start && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rw_start_seen", ht_start, 1);
        repeat (3) @(posedge clk);
        #3;
        chk("rw_x", ht_x, 5);
        chk("rw_y", ht_y, 1);
        chk("rw_edge_count", edge_count, 1);
        chk("rw_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("rw_rst_busy", busy, 0);
        chk("rw_rst_ht_start", ht_start, 0);
        chk("rw_rst_frame_done", frame_done, 0);
        chk("rw_rst_edge_count", edge_count, 0);
        chk("rw_rst_edge_addr", edge_addr, 0);
        chk("rw_rst_ht_x", ht_x, 0);
        chk("rw_rst_ht_y", ht_y, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fdc = 0;
        bsy = 0;
        repeat (10) begin
            @(negedge clk);
            if (frame_done) fdc++;
            if (busy) bsy++;
        end
        chk("rw_no_frame_done", fdc, 0);
        chk("rw_stays_idle", bsy, 0);

        // Restart after the abort begins at (0,0).
        clear_bmp();
        bmp[0] = 1'b1;
        run_frame(2, 1'b0, 0);
        chk("rs_starts", hs_cnt, 1);
        chk("rs_x", lx[0], 0);
        chk("rs_y", ly[0], 0);
        chk("rs_addr", la[0], 0);
        chk("rs_fd_cycle", fd_rel, 68);
        chk("rs_edge_count", edge_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
